// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one bram_fifo write port between NUM_REQ channels.
// Optional per-channel accepted-beat counters when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
    output logic [CNT_WIDTH-1:0]          stat_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] grant_id_nxt;
    logic [ID_W-1:0] last_grant, last_grant_nxt;
    logic [BC_W-1:0] burst_cnt, burst_cnt_nxt;
    logic            beat;
    logic            found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            burst_cnt  <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_id_nxt;
            burst_cnt  <= burst_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        req_ready      = '0;
        fifo_wr_en     = 1'b0;
        fifo_wr_data   = '0;
        beat           = 1'b0;
        found          = 1'b0;
        case (state)
            IDLE: begin
                // Search starts one past the last released channel and wraps.
                for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                    if (!found && req_valid[(32'(last_grant) + off) % NUM_REQ]) begin
                        found         = 1'b1;
                        grant_id_nxt  = ID_W'((32'(last_grant) + off) % NUM_REQ);
                        burst_cnt_nxt = '0;
                        state_nxt     = GRANT;
                    end
                end
            end
            GRANT: begin
                req_ready[grant_id] = !fifo_full;
                beat                = req_valid[grant_id] && !fifo_full;
                fifo_wr_en          = beat;
                fifo_wr_data        = req_data[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                if (!req_valid[grant_id]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_id;
                end else if (beat) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == BC_W'(MAX_BURST - 1)) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_id;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A beat presented in the reset cycle must not reach the FIFO.
        if (rst) begin
            req_ready    = '0;
            fifo_wr_en   = 1'b0;
            fifo_wr_data = '0;
            beat         = 1'b0;
        end
    end

    assign busy = (state == GRANT) && !rst;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
            stat_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (beat && grant_id == ID_W'(i) && stat_cnt[i] != '1)
                    stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
            stat_count <= stat_cnt[stat_sel];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (MAX_BURST=4): vector table plus burst, stall,
// reset and statistics sequences.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;
    logic [1:0]  stat_sel;
    logic [15:0] stat_count;

    int passed = 0;
    int total  = 0;

`ifdef FIFO_ARB_STATS_EN
    localparam logic [15:0] EXP_STAT32 = 16'd32;
`else
    localparam logic [15:0] EXP_STAT32 = 16'd0;
`endif

    fifo_write_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .MAX_BURST (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full   (fifo_full),
        .grant_id    (grant_id),
        .busy        (busy),
        .stat_sel    (stat_sel),
        .stat_count  (stat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic [3:0]  er;
        logic        ew;
        logic [7:0]  ed;
        logic        eb;
        logic [1:0]  eg;
    } vec_t;

    vec_t vt [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] er, input logic ew,
                         input logic [7:0] ed, input logic eb, input logic [1:0] eg);
        total++;
        if ({req_ready, fifo_wr_en, fifo_wr_data, busy, grant_id} !== {er, ew, ed, eb, eg})
            $display("FAIL %s: got ready=%b wr_en=%b data=%h busy=%b gid=%0d, want ready=%b wr_en=%b data=%h busy=%b gid=%0d",
                     name, req_ready, fifo_wr_en, fifo_wr_data, busy, grant_id, er, ew, ed, eb, eg);
        else
            passed++;
    endtask

    task automatic check_stat(input string name, input logic [15:0] exp);
        total++;
        if (stat_count !== exp)
            $display("FAIL %s: got stat_count=%0d, want %0d", name, stat_count, exp);
        else
            passed++;
    endtask

    logic [7:0] cnt1, cnt2, cnt3, cnt0;
    logic [1:0] prev_g;
    logic       fs [7];
    logic [7:0] eds [7];

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; stat_sel = '0;
        repeat (2) @(posedge clk);

        // Ch0 five beats with burst cap 4: 4 beats, one arbitration cycle, 1 beat, drain.
        vt[0] = '{1'b1, 4'b0000, 32'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vt[1] = '{1'b0, 4'b0001, 32'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vt[2] = '{1'b0, 4'b0001, 32'h00, 1'b0, 4'b0001, 1'b1, 8'h00, 1'b1, 2'd0};
        vt[3] = '{1'b0, 4'b0001, 32'h01, 1'b0, 4'b0001, 1'b1, 8'h01, 1'b1, 2'd0};
        vt[4] = '{1'b0, 4'b0001, 32'h02, 1'b0, 4'b0001, 1'b1, 8'h02, 1'b1, 2'd0};
        vt[5] = '{1'b0, 4'b0001, 32'h03, 1'b0, 4'b0001, 1'b1, 8'h03, 1'b1, 2'd0};
        vt[6] = '{1'b0, 4'b0001, 32'h04, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vt[7] = '{1'b0, 4'b0001, 32'h04, 1'b0, 4'b0001, 1'b1, 8'h04, 1'b1, 2'd0};
        vt[8] = '{1'b0, 4'b0000, 32'h00, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0};
        vt[9] = '{1'b0, 4'b0000, 32'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

        for (int i = 0; i < 10; i++) begin
            tick();
            rst = vt[i].rst; req_valid = vt[i].valid; req_data = vt[i].data; fifo_full = vt[i].full;
            @(negedge clk);
            check($sformatf("vec%0d", i), vt[i].er, vt[i].ew, vt[i].ed, vt[i].eb, vt[i].eg);
        end

        // Ch1 and ch2 contend continuously: 4-beat bursts alternate, idle cycle between.
        cnt1 = '0; cnt2 = '0; prev_g = 2'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 1; c <= 2; c++) begin
                tick();
                req_valid = 4'b0110;
                req_data  = {8'h00, 8'h80 + cnt2, 8'h40 + cnt1, 8'h00};
                @(negedge clk);
                check("rr_idle", 4'b0000, 1'b0, 8'h00, 1'b0, prev_g);
                for (int b = 0; b < 4; b++) begin
                    tick();
                    req_data = {8'h00, 8'h80 + cnt2, 8'h40 + cnt1, 8'h00};
                    @(negedge clk);
                    check($sformatf("rr_r%0d_ch%0d_b%0d", r, c, b), 4'b0001 << c, 1'b1,
                          (c == 1 ? 8'h40 : 8'h80) + 8'(r*4 + b), 1'b1, 2'(c));
                    if (req_ready[1] && req_valid[1]) cnt1++;
                    if (req_ready[2] && req_valid[2]) cnt2++;
                end
                prev_g = 2'(c);
            end
        end

        tick(); req_valid = '0; stat_sel = 2'd1;
        tick(); stat_sel = 2'd0;
        @(negedge clk); check_stat("stat_ch1", EXP_STAT32);
        tick(); stat_sel = 2'd2;
        @(negedge clk); check_stat("stat_ch0", 16'd0);
        tick();
        @(negedge clk); check_stat("stat_ch2", EXP_STAT32);

        // Ch3 burst with a 3-cycle fifo_full stall after two beats.
        fs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        eds = '{8'hC0, 8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC3};
        cnt3 = '0;
        tick(); req_valid = 4'b1000; req_data = {8'hC0, 24'h0};
        @(negedge clk); check("full_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        for (int k = 0; k < 7; k++) begin
            tick();
            fifo_full = fs[k]; req_data = {8'hC0 + cnt3, 24'h0};
            @(negedge clk);
            check($sformatf("full_c%0d", k), fs[k] ? 4'b0000 : 4'b1000, !fs[k], eds[k], 1'b1, 2'd3);
            if (req_ready[3] && req_valid[3]) cnt3++;
        end
        tick(); req_valid = '0; fifo_full = 1'b0;
        @(negedge clk); check("full_release", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);

        // Reset during beat 2 of a ch0 burst; ch0 must win again afterwards despite ch1.
        cnt0 = '0; stat_sel = 2'd1;
        tick(); req_valid = 4'b0001; req_data = {24'h0, 8'h50};
        @(negedge clk); check("rst_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);
        for (int b = 0; b < 2; b++) begin
            tick(); req_data = {24'h0, 8'h50 + cnt0};
            @(negedge clk);
            check($sformatf("rst_b%0d", b), 4'b0001, 1'b1, 8'h50 + 8'(b), 1'b1, 2'd0);
            if (req_ready[0] && req_valid[0]) cnt0++;
        end
        tick(); rst = 1'b1; req_data = {24'h0, 8'h50 + cnt0};
        @(negedge clk); check("rst_cycle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        tick(); rst = 1'b0; req_valid = 4'b0011; req_data = {16'h0, 8'h60, 8'h50 + cnt0};
        @(negedge clk); check("rst_after", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        check_stat("stat_cleared", 16'd0);
        tick();
        @(negedge clk); check("rst_regrant", 4'b0001, 1'b1, 8'h52, 1'b1, 2'd0);

        tick(); req_valid = '0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
